mmio_out_fifo: RTL and testbench
================================

# mmio_out_fifo

Parametrised memory-mapped output FIFO: successor to the single 16-bit LCD holding register between the memory controller's peripheral write strobe and a slow consumer such as the LCD controller. CPU stores are queued instead of overwriting each other. A ready/valid handshake drains them at the consumer's pace. Occupancy and a sticky overflow flag are exported for status readback.

## Interface
Parameters:
- `DATA_W`, 16, width of each queued word.
- `DEPTH`, 8, number of entries; power of two, ≥ 2.
- `AW`, 3, pointer width; must equal log2(DEPTH).

Ports:
- `CLK_50MHZ`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  one-cycle write strobe from the memory controller (peripheral address decode).
- `wr_data`  in  DATA_W  word written by the CPU store.
- `out_valid`  out  1  head entry is available.
- `out_data`  out  DATA_W  head entry.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write arrived while full.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- Storage: DEPTH×DATA_W register array, write pointer `wp` and read pointer `rp` (AW bits, natural wrap DEPTH-1→0), occupancy counter `count` (AW+1 bits).
- `out_valid` = !empty. `out_data` = mem[rp], driven combinationally from the array. `out_data` is don't-care when empty.
- Pop: `out_valid && out_ready` at the edge → rp+1, count−1.
- Push: `wr_en && !full` at the edge → mem[wp]=wr_data, wp+1, count+1.
- Simultaneous push and pop with 0 < count < DEPTH: both happen, count unchanged.
- Full with simultaneous push and pop: both happen, count stays DEPTH, overflow not set.
- Empty with simultaneous `wr_en` and `out_ready`: push only (no pop, since `out_valid`=0). count becomes 1.
- Full with push and no pop: behaviour depends on the configuration (see Configuration). `overflow` is set in both cases.
- `overflow`: set on a write-while-full; cleared by `clr_overflow`. If both occur in the same cycle, set wins.
- `out_ready` while empty: ignored, no state change.
- Reset (any time, including mid-drain): `wp`=`rp`=0, count=0, overflow=0. Array contents are not cleared. Outputs: `out_valid`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0. Any pending handshake is lost.

## Timing
- Write-to-visible latency is 1 cycle. A word pushed at edge N appears on `out_valid`/`out_data` after edge N when the FIFO was empty.
- `full`, `empty`, `count` and `overflow` are registered or derived only from registers. All update after the causing edge.
- No combinational path exists from `out_ready` or `wr_en` to any output.
- Throughput: one push and one pop per cycle sustained.
- Consumer rule: `out_data` is held stable while `out_valid`=1 and `out_ready`=0, except in overwrite mode when full (see Configuration).
- Reset assertion clears state asynchronously. Deassertion is used synchronously; the first push is possible on the first edge after release.

## Configuration
- `MMIO_FIFO_OVERWRITE_EN` undefined (default): a write while full with no pop is dropped. Array, pointers and count are unchanged.
- `MMIO_FIFO_OVERWRITE_EN` defined: a write while full with no pop overwrites the oldest entry.
  - mem[wp]=wr_data; wp+1 and rp+1; count stays DEPTH.
  - `out_data` changes to the next-oldest entry after that edge, even if `out_valid` was held high without `out_ready`.
  - The displayed stream therefore always keeps the newest DEPTH words.

## Test plan
- Reset, then push 0x1111, 0x2222, 0x3333 with `out_ready`=0 → count=3, `out_data`=0x1111. Then hold `out_ready`=1 for 3 cycles → data 0x1111, 0x2222, 0x3333 in order, then `empty`=1, count=0.
- DEPTH=8: push 0x0000..0x0007, then push 0x00AA → `full`=1, `overflow`=1.
  - Default build: drain yields 0x0000..0x0007.
  - Overwrite build: drain yields 0x0001..0x0007, 0x00AA.
- Full FIFO, `wr_en`=1 with 0x0BEE and `out_ready`=1 in the same cycle → count stays 8, `overflow` stays 0, 0x0BEE is the last word drained.
- Empty FIFO, `wr_en`=1 with 0x5A5A and `out_ready`=1 in the same cycle → count=1, `out_valid`=1, `out_data`=0x5A5A next cycle.
- Assert `overflow`, then drive `clr_overflow`=1 in the same cycle as a write to the full FIFO → `overflow` remains 1. Next cycle `clr_overflow`=1 alone → `overflow`=0.
- Push 5 words, pop 2, then pulse `reset` low for 1 ns mid-cycle → outputs immediately `empty`=1, count=0, `out_valid`=0. A subsequent push of 0x7777 → `out_data`=0x7777 from slot 0.

Source files
------------

// File: rtl/mmio_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mmio_out_fifo                                                |
// | Description : Memory-mapped output FIFO between the memory controller's    |
// |               peripheral write strobe and a slow consumer (e.g. the LCD    |
// |               controller). CPU stores are queued and drained through a     |
// |               ready/valid handshake. Occupancy and a sticky overflow flag  |
// |               are exported for status readback.                           |
// | Option      : define MMIO_FIFO_OVERWRITE_EN to make a write into a full    |
// |               FIFO (with no simultaneous pop) replace the oldest entry     |
// |               instead of being dropped.                                    |
// | Ports       : CLK_50MHZ    - system clock, rising edge                     |
// |               reset        - asynchronous active-low reset                 |
// |               wr_en        - one-cycle write strobe                        |
// |               wr_data      - word to queue                                 |
// |               out_valid    - head entry available                          |
// |               out_data     - head entry                                    |
// |               out_ready    - consumer accepts head this cycle              |
// |               full/empty   - occupancy == DEPTH / == 0                     |
// |               count        - occupancy 0..DEPTH                            |
// |               overflow     - sticky write-while-full flag                  |
// |               clr_overflow - clears overflow (a new set wins)              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mmio_out_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic              CLK_50MHZ,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [AW:0]       r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;
  logic w_ovf_set;
  logic w_ovw;
  logic w_write;
  logic w_adv_rp;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);

  // A pop frees a slot in the same edge, so a full FIFO still accepts a write
  // when the consumer takes the head at the same time.
  assign w_pop     = !w_empty && out_ready;
  assign w_push    = wr_en && (!w_full || w_pop);
  assign w_ovf_set = wr_en && w_full && !w_pop;

`ifdef MMIO_FIFO_OVERWRITE_EN
  // Overwrite the oldest slot: wp == rp when full, so writing mem[wp] and
  // advancing both pointers discards the head and keeps the newest DEPTH words.
  assign w_ovw = w_ovf_set;
`else
  assign w_ovw = 1'b0;
`endif

  assign w_write  = w_push || w_ovw;
  assign w_adv_rp = w_pop || w_ovw;

  // Storage is deliberately not reset; only pointers and count define validity.
  always_ff @(posedge CLK_50MHZ) begin
    if (w_write) begin
      r_mem[r_wp] <= wr_data;
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_write) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_adv_rp) begin
        r_rp <= r_rp + AW'(1);
      end
      // Overwrite leaves count at DEPTH, so only true push/pop move it.
      if (w_push && !w_pop) begin
        r_count <= r_count + (AW+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (AW+1)'(1);
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rp];
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mmio_out_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mmio_out_fifo                                             |
// | Description : Self-checking bench for mmio_out_fifo. A queue-based         |
// |               reference model tracks the expected contents and the sticky  |
// |               overflow flag; directed scenarios are followed by a random   |
// |               push/pop/clear sequence. Honours MMIO_FIFO_OVERWRITE_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mmio_out_fifo;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              full;
  logic              empty;
  logic [AW:0]       count;
  logic              overflow;
  logic              clr_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue front is the head entry.
  logic [DATA_W-1:0] q[$];
  bit                m_ovf;

  mmio_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK_50MHZ    (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"},     32'(count),     32'(q.size()));
    check({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    check({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    if (q.size() != 0) begin
      check({tag, ".out_data"}, 32'(out_data), 32'(q[0]));
    end
  endtask

  // Drives one cycle of inputs, advances the model by the FIFO rules, then
  // samples the DUT 1 ns after the edge.
  task automatic cycle(input string tag, input logic we, input logic [DATA_W-1:0] wd,
                       input logic rdy, input logic clr);
    bit mfull;
    bit mpop;
    wr_en        = we;
    wr_data      = wd;
    out_ready    = rdy;
    clr_overflow = clr;
    mfull = (q.size() == DEPTH);
    mpop  = rdy && (q.size() != 0);
    @(posedge clk);
    if (we && mfull && !mpop) m_ovf = 1'b1;
    else if (clr)             m_ovf = 1'b0;
    if (mpop) q.delete(0);
    if (we) begin
      if (!mfull || mpop) begin
        q.push_back(wd);
      end else begin
`ifdef MMIO_FIFO_OVERWRITE_EN
        q.delete(0);
        q.push_back(wd);
`endif
      end
    end
    #1;
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b0;
    wr_en        = 1'b0;
    wr_data      = '0;
    out_ready    = 1'b0;
    clr_overflow = 1'b0;
    m_ovf        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    reset = 1'b1;

    // Three ordered writes with consumer stalled, then drain.
    cycle("tp1_w0", 1'b1, 16'h1111, 1'b0, 1'b0);
    cycle("tp1_w1", 1'b1, 16'h2222, 1'b0, 1'b0);
    cycle("tp1_w2", 1'b1, 16'h3333, 1'b0, 1'b0);
    check("tp1_count3", 32'(count), 32'd3);
    check("tp1_head", 32'(out_data), 32'h1111);
    cycle("tp1_r0", 1'b0, 16'h0, 1'b1, 1'b0);
    check("tp1_second", 32'(out_data), 32'h2222);
    cycle("tp1_r1", 1'b0, 16'h0, 1'b1, 1'b0);
    cycle("tp1_r2", 1'b0, 16'h0, 1'b1, 1'b0);
    check("tp1_empty", 32'(empty), 32'd1);

    // Fill, then write-while-full.
    for (int i = 0; i < DEPTH; i++) cycle("tp2_fill", 1'b1, DATA_W'(i), 1'b0, 1'b0);
    cycle("tp2_ovf", 1'b1, 16'h00AA, 1'b0, 1'b0);
    check("tp2_full", 32'(full), 32'd1);
    check("tp2_overflow", 32'(overflow), 32'd1);
`ifdef MMIO_FIFO_OVERWRITE_EN
    check("tp2_head", 32'(out_data), 32'h0001);
`else
    check("tp2_head", 32'(out_data), 32'h0000);
`endif
    for (int i = 0; i < DEPTH; i++) cycle("tp2_drain", 1'b0, 16'h0, 1'b1, 1'b0);

    // Full with simultaneous push and pop.
    cycle("tp3_clr", 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) cycle("tp3_fill", 1'b1, DATA_W'(16'h0100 + i), 1'b0, 1'b0);
    cycle("tp3_pp", 1'b1, 16'h0BEE, 1'b1, 1'b0);
    check("tp3_count8", 32'(count), 32'd8);
    check("tp3_noovf", 32'(overflow), 32'd0);

    // Set beats clear in the same cycle, clear alone then works.
    cycle("tp5_setclr", 1'b1, 16'h1234, 1'b0, 1'b1);
    check("tp5_kept", 32'(overflow), 32'd1);
    cycle("tp5_clr", 1'b0, 16'h0, 1'b0, 1'b1);
    check("tp5_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) cycle("tp3_drain", 1'b0, 16'h0, 1'b1, 1'b0);

    // Empty with simultaneous write and ready: push only.
    cycle("tp4_wr", 1'b1, 16'h5A5A, 1'b1, 1'b0);
    check("tp4_count1", 32'(count), 32'd1);
    check("tp4_data", 32'(out_data), 32'h5A5A);
    cycle("tp4_drain", 1'b0, 16'h0, 1'b1, 1'b0);
    cycle("tp4_idle_ready", 1'b0, 16'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-drain.
    for (int i = 0; i < 5; i++) cycle("tp6_fill", 1'b1, DATA_W'(16'h0600 + i), 1'b0, 1'b0);
    cycle("tp6_pop0", 1'b0, 16'h0, 1'b1, 1'b0);
    cycle("tp6_pop1", 1'b0, 16'h0, 1'b1, 1'b0);
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_state("tp6_async");
    reset = 1'b1;
    cycle("tp6_wr", 1'b1, 16'h7777, 1'b0, 1'b0);
    check("tp6_data", 32'(out_data), 32'h7777);
    cycle("tp6_drain", 1'b0, 16'h0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle("rand",
            ($urandom_range(0, 99) < 60),
            DATA_W'($urandom),
            ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 8));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
